// File: rtl/co_result_collector.sv
// Result return path: sequences one operation, captures the selected unit's result
// and presents it (or an error) until the consumer accepts it.
module co_result_collector #(
    parameter int unsigned W       = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           from_mul,
    input  logic           from_div,
    input  logic           from_sqr,
    input  logic [2*W-1:0] alu_res,
    input  logic           alu_valid,
    input  logic [2*W-1:0] mul_res,
    input  logic           mul_done,
    input  logic [W-1:0]   div_q,
    input  logic [W-1:0]   div_r,
    input  logic           div_done,
    input  logic           div_by_zero,
    input  logic [W-1:0]   sqr_res,
    input  logic           sqr_done,
    output logic [2*W-1:0] res,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           busy,
    output logic           err,
    output logic [1:0]     err_code
);

    typedef enum logic [1:0] {StIdle, StWait, StHold, StErr} state_e;

    localparam logic [2:0] ModeAlu = 3'b000;
    localparam logic [2:0] ModeMul = 3'b100;
    localparam logic [2:0] ModeDiv = 3'b010;
    localparam logic [2:0] ModeSqr = 3'b001;

    localparam logic [1:0] CodeNone    = 2'b00;
    localparam logic [1:0] CodeTimeout = 2'b01;
    localparam logic [1:0] CodeDivZero = 2'b10;
    localparam logic [1:0] CodeIllegal = 2'b11;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [2:0]     mode_q, mode_d;
    logic [2*W-1:0] res_q, res_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [1:0]     code_q, code_d;

    logic [2:0]     mode_in;
    logic           mode_in_legal;
    logic [W-1:0]   div_q_rev, div_r_rev;
    logic           sel_done;
    logic [2*W-1:0] sel_res;
    logic [7:0]     cnt_inc;

    assign mode_in       = {from_mul, from_div, from_sqr};
    // Legal modes are all-zero or exactly one bit set.
    assign mode_in_legal = ($countones(mode_in) <= 1);
    assign cnt_inc       = cnt_q + 8'd1;

    // The divider returns its fields bit-reversed; restore natural order.
    always_comb begin
        div_q_rev = '0;
        div_r_rev = '0;
        for (int unsigned i = 0; i < W; i++) begin
            div_q_rev[i] = div_q[W-1-i];
            div_r_rev[i] = div_r[W-1-i];
        end
    end

    always_comb begin
        sel_done = 1'b0;
        sel_res  = '0;
        case (mode_q)
            ModeAlu: begin
                sel_done = alu_valid;
                sel_res  = alu_res;
            end
            ModeMul: begin
                sel_done = mul_done;
                sel_res  = mul_res;
            end
            ModeDiv: begin
                sel_done = div_done;
                sel_res  = {div_q_rev, div_r_rev};
            end
            ModeSqr: begin
                sel_done = sqr_done;
                sel_res  = {{W{1'b0}}, sqr_res};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        res_d   = res_q;
        valid_d = valid_q;
        err_d   = err_q;
        code_d  = code_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d = mode_in;
                    cnt_d  = 8'd0;
                    if (mode_in_legal) begin
                        state_d = StWait;
                    end else begin
                        state_d = StErr;
                        res_d   = '0;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        code_d  = CodeIllegal;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_inc;
                // A done landing on the timeout cycle takes priority.
                if (sel_done) begin
                    valid_d = 1'b1;
                    if (mode_q == ModeDiv && div_by_zero) begin
                        state_d = StErr;
                        res_d   = '0;
                        err_d   = 1'b1;
                        code_d  = CodeDivZero;
                    end else begin
                        state_d = StHold;
                        res_d   = sel_res;
                    end
                end else if (cnt_inc == TimeoutCnt) begin
                    state_d = StErr;
                    res_d   = '0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    code_d  = CodeTimeout;
                end
            end
            StHold: begin
                if (res_ready) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            end
            StErr: begin
                if (res_ready) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    code_d  = CodeNone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            mode_q  <= 3'b000;
            res_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= CodeNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign res       = res_q;
    assign res_valid = valid_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_co_result_collector.sv
// Self-checking bench for co_result_collector: directed vector table, reset sequence and
// randomized operations checked against a behavioural model.
module tb_co_result_collector;

    localparam int unsigned W       = 4;
    localparam int unsigned TIMEOUT = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           from_mul = 1'b0, from_div = 1'b0, from_sqr = 1'b0;
    logic [2*W-1:0] alu_res = '0, mul_res = '0;
    logic           alu_valid = 1'b0, mul_done = 1'b0;
    logic [W-1:0]   div_q = '0, div_r = '0, sqr_res = '0;
    logic           div_done = 1'b0, div_by_zero = 1'b0, sqr_done = 1'b0;
    logic [2*W-1:0] res;
    logic           res_valid, res_ready = 1'b0, busy, err;
    logic [1:0]     err_code;

    int checks = 0;
    int failures = 0;

    co_result_collector #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .from_mul(from_mul), .from_div(from_div), .from_sqr(from_sqr),
        .alu_res(alu_res), .alu_valid(alu_valid),
        .mul_res(mul_res), .mul_done(mul_done),
        .div_q(div_q), .div_r(div_r), .div_done(div_done), .div_by_zero(div_by_zero),
        .sqr_res(sqr_res), .sqr_done(sqr_done),
        .res(res), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mode;
        int         k;      // WAIT cycle (1-based) in which the selected done fires
        logic [7:0] a;
        logic [7:0] m;
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        logic [3:0] s;
        int         rdel;   // HOLD/ERR cycles before res_ready
        logic [7:0] exp_res;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // quiet bit 0 ALU, 1 MUL, 2 DIV, 3 SQR: that unit's done is held low.
    task automatic noise(input logic [3:0] quiet);
        alu_res     = 8'($urandom);
        mul_res     = 8'($urandom);
        div_q       = 4'($urandom);
        div_r       = 4'($urandom);
        sqr_res     = 4'($urandom);
        div_by_zero = 1'($urandom);
        alu_valid   = quiet[0] ? 1'b0 : ($urandom_range(0, 2) == 0);
        mul_done    = quiet[1] ? 1'b0 : ($urandom_range(0, 2) == 0);
        div_done    = quiet[2] ? 1'b0 : ($urandom_range(0, 2) == 0);
        sqr_done    = quiet[3] ? 1'b0 : ($urandom_range(0, 2) == 0);
    endtask

    function automatic logic [3:0] unit_mask(input logic [2:0] mode);
        case (mode)
            3'b000:  return 4'b0001;
            3'b100:  return 4'b0010;
            3'b010:  return 4'b0100;
            3'b001:  return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int rev_model(input logic [3:0] x);
        int v = 0;
        for (int i = 0; i < int'(W); i++) if (x[i]) v += 1 << (int'(W) - 1 - i);
        return v;
    endfunction

    // Returns {err_code, res} for one operation.
    function automatic logic [9:0] model(input logic [2:0] mode, input int k, input logic [7:0] a,
                                         input logic [7:0] m, input logic [3:0] q,
                                         input logic [3:0] r, input logic dbz,
                                         input logic [3:0] s);
        int v;
        if (!(mode == 3'b000 || mode == 3'b100 || mode == 3'b010 || mode == 3'b001))
            return {2'd3, 8'd0};
        if (k > int'(TIMEOUT)) return {2'd1, 8'd0};
        case (mode)
            3'b000: return {2'd0, a};
            3'b100: return {2'd0, m};
            3'b010: begin
                if (dbz) return {2'd2, 8'd0};
                v = rev_model(q) * (1 << W) + rev_model(r);
                return {2'd0, 8'(v)};
            end
            default: return {2'd0, 4'd0, s};
        endcase
    endfunction

    task automatic run_op(input vec_t v, input string name);
        logic legal;
        logic done_flag;
        int   c;
        legal = (unit_mask(v.mode) != 4'b0000);
        noise(4'b0000);
        start = 1'b0;
        res_ready = 1'($urandom);
        step();
        check({name, " idle"}, {busy, res_valid}, 2'b00);
        {from_mul, from_div, from_sqr} = v.mode;
        start = 1'b1;
        step();
        start = 1'b0;
        if (legal) begin
            check({name, " wait_entry"}, {busy, res_valid, err}, 3'b100);
            done_flag = 1'b0;
            c = 0;
            while (!done_flag && c < int'(TIMEOUT) + 2) begin
                c++;
                noise(unit_mask(v.mode));
                {from_mul, from_div, from_sqr} = 3'($urandom);
                start = 1'($urandom);
                res_ready = 1'($urandom);
                if (c == v.k) begin
                    case (v.mode)
                        3'b000: begin alu_valid = 1'b1; alu_res = v.a; end
                        3'b100: begin mul_done = 1'b1; mul_res = v.m; end
                        3'b010: begin
                            div_done = 1'b1; div_q = v.q; div_r = v.r; div_by_zero = v.dbz;
                        end
                        default: begin sqr_done = 1'b1; sqr_res = v.s; end
                    endcase
                end
                step();
                if ((c == v.k && v.k <= int'(TIMEOUT)) || c == int'(TIMEOUT)) done_flag = 1'b1;
                else check({name, " waiting"}, {busy, res_valid}, 2'b10);
            end
            if (!done_flag) check({name, " wait_bound"}, 1'b0, 1'b1);
        end
        for (int rr = 0; rr <= v.rdel; rr++) begin
            check({name, " present"}, {busy, res_valid, err, err_code, res},
                  {1'b1, 1'b1, v.exp_code != 2'd0, v.exp_code, v.exp_res});
            noise(4'b0000);
            {from_mul, from_div, from_sqr} = 3'($urandom);
            start = 1'($urandom);
            res_ready = (rr == v.rdel);
            step();
        end
        check({name, " consumed"}, {busy, res_valid, err, err_code, res},
              {1'b0, 1'b0, 1'b0, 2'b00, v.exp_res});
        res_ready = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        vec_t rv;
        logic [9:0] e;
        vecs[0]  = '{3'b000, 2,  8'h5A, 8'h00, 4'h0,    4'h0,    1'b0, 4'h0, 1, 8'h5A, 2'd0};
        vecs[1]  = '{3'b010, 3,  8'h00, 8'h00, 4'b1000, 4'b0110, 1'b0, 4'h0, 0, 8'h16, 2'd0};
        vecs[2]  = '{3'b010, 3,  8'h00, 8'h00, 4'b1000, 4'b0110, 1'b1, 4'h0, 2, 8'h00, 2'd2};
        vecs[3]  = '{3'b100, 40, 8'h00, 8'h51, 4'h0,    4'h0,    1'b0, 4'h0, 1, 8'h00, 2'd1};
        vecs[4]  = '{3'b100, 16, 8'h00, 8'h51, 4'h0,    4'h0,    1'b0, 4'h0, 0, 8'h51, 2'd0};
        vecs[5]  = '{3'b110, 1,  8'h00, 8'h00, 4'h0,    4'h0,    1'b0, 4'h0, 3, 8'h00, 2'd3};
        vecs[6]  = '{3'b001, 4,  8'h00, 8'h00, 4'h0,    4'h0,    1'b0, 4'hB, 5, 8'h0B, 2'd0};
        vecs[7]  = '{3'b000, 1,  8'hC3, 8'h00, 4'h0,    4'h0,    1'b0, 4'h0, 0, 8'hC3, 2'd0};
        vecs[8]  = '{3'b100, 17, 8'h00, 8'hEE, 4'h0,    4'h0,    1'b0, 4'h0, 0, 8'h00, 2'd1};
        vecs[9]  = '{3'b111, 1,  8'h00, 8'h00, 4'h0,    4'h0,    1'b0, 4'h0, 0, 8'h00, 2'd3};
        vecs[10] = '{3'b011, 1,  8'h00, 8'h00, 4'h0,    4'h0,    1'b0, 4'h0, 1, 8'h00, 2'd3};
        vecs[11] = '{3'b010, 15, 8'h00, 8'h00, 4'b0011, 4'b1101, 1'b0, 4'h0, 0, 8'hCB, 2'd0};

        rst = 1'b1;
        noise(4'b0000);
        start = 1'b1;
        step();
        step();
        check("reset_state", {busy, res_valid, err, err_code, res}, 13'd0);
        rst = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 12; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-WAIT abandons the operation; a late done is ignored.
        {from_mul, from_div, from_sqr} = 3'b100;
        start = 1'b1;
        noise(4'b0010);
        step();
        start = 1'b0;
        step();
        check("rst_pre_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        check("rst_mid_wait", {busy, res_valid, err, err_code, res}, 13'd0);
        rst = 1'b0;
        mul_done = 1'b1;
        mul_res = 8'hFF;
        step();
        check("rst_late_done", {busy, res_valid, err, err_code, res}, 13'd0);
        mul_done = 1'b0;
        step();
        check("rst_still_idle", {busy, res_valid}, 2'b00);
        run_op(vecs[0], "post_rst_alu");

        for (int n = 0; n < 40; n++) begin
            rv.mode = ($urandom_range(0, 1) == 0) ? 3'($urandom) :
                      (($urandom_range(0, 3) == 0) ? 3'b000 : (3'b001 << $urandom_range(0, 2)));
            rv.k    = $urandom_range(1, TIMEOUT + 3);
            rv.a    = 8'($urandom);
            rv.m    = 8'($urandom);
            rv.q    = 4'($urandom);
            rv.r    = 4'($urandom);
            rv.dbz  = ($urandom_range(0, 3) == 0);
            rv.s    = 4'($urandom);
            rv.rdel = $urandom_range(0, 4);
            e = model(rv.mode, rv.k, rv.a, rv.m, rv.q, rv.r, rv.dbz, rv.s);
            rv.exp_code = e[9:8];
            rv.exp_res  = e[7:0];
            run_op(rv, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/co_result_collector.md
Name: co_result_collector

Overview:
- Return path of the shared operand registers: collects the result of whichever unit (ALU, multiplier, divisor, square-root) is selected for the current operation and presents it as a single result word to the display/accumulator stage.
- Uses the same mode-select encoding as the operand distribution path.
- Sequences each operation: start, wait for the unit, hold the result until it is consumed.
- Reports timeout, divide-by-zero and illegal-mode errors.

Parameters:
W, 4, operand width; the result bus is 2*W bits.
TIMEOUT, 16, maximum cycles spent in WAIT before a timeout error; valid range is 1 to 255.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; latches the mode select and begins collection
from_mul  in  1  mode select bit 2
from_div  in  1  mode select bit 1
from_sqr  in  1  mode select bit 0
alu_res  in  2W  ALU result
alu_valid  in  1  ALU result valid
mul_res  in  2W  multiplier product
mul_done  in  1  multiplier done
div_q  in  W  divisor quotient, bit-reversed order
div_r  in  W  divisor remainder, bit-reversed order
div_done  in  1  divisor done
div_by_zero  in  1  qualified by div_done
sqr_res  in  W  square-root result
sqr_done  in  1  square-root done
res  out  2W  registered result
res_valid  out  1  result or error is presented
res_ready  in  1  consumer accepts the presented result
busy  out  1  high whenever state is not IDLE
err  out  1  error is presented
err_code  out  2  error code: 00 none, 01 timeout, 10 divide-by-zero, 11 illegal mode

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state goes to IDLE; cycle counter cleared; latched mode cleared.
  - res=0, res_valid=0, err=0, err_code=00, busy=0.
  - Reset wins over every other input, including mid-operation; the operation in flight is abandoned and any later done pulse is ignored.
- State machine: IDLE, WAIT, HOLD, ERR.
- IDLE:
  - On start=1, latch mode={from_mul,from_div,from_sqr}.
  - Legal modes: 000 ALU, 100 MUL, 010 DIV, 001 SQR. A legal mode goes to WAIT with counter=0.
  - Any other mode goes to ERR with err_code=11 and res=0.
  - Done/valid inputs seen in IDLE are ignored.
- WAIT:
  - Only the latched unit's done/valid is sampled; the other units' done signals are ignored.
  - The latched mode is frozen; from_* changes have no effect.
  - start is ignored.
  - The counter increments every cycle spent in WAIT.
- Capture in WAIT, when the selected unit's done/valid is 1 at edge n:
  - ALU: res=alu_res.
  - MUL: res=mul_res.
  - DIV: res={rev(div_q), rev(div_r)}, where rev swaps bit i with bit W-1-i. This undoes the bit reversal applied on the operand path.
  - SQR: res={W zeros, sqr_res}.
- After capture:
  - At edge n, state goes to HOLD; res_valid=1 during cycle n+1 (one-cycle latency).
  - DIV with div_by_zero=1 goes to ERR instead, with err_code=10 and res=0.
- Timeout:
  - If the counter reaches TIMEOUT (i.e. TIMEOUT full cycles in WAIT without done), go to ERR with err_code=01 and res=0.
  - If done and timeout occur in the same cycle, done wins.
- HOLD:
  - res_valid=1; res is stable.
  - On res_ready=1, return to IDLE next edge with res_valid=0. res keeps its value afterwards.
  - start and done inputs are ignored.
  - res_ready held high beforehand is legal; the result is consumed on the first HOLD cycle.
- ERR:
  - res_valid=1, err=1, err_code held.
  - On res_ready=1, return to IDLE with err=0, err_code=00, res_valid=0.
- Back-to-back operations: a start arriving in the same cycle as res_ready in HOLD or ERR is ignored. A new start is accepted only in IDLE, so the minimum spacing between operations is one IDLE cycle.
- busy is combinational from state (state not IDLE). All other outputs are registered.

Test Plan:
- Reset, then start with mode 000 and alu_valid=1 with alu_res=0x5A two cycles later -> res=0x5A, res_valid=1 one cycle after alu_valid. Assert res_ready -> res_valid=0 and busy=0 next cycle; res stays 0x5A.
- Mode 010, div_q=4'b1000 and div_r=4'b0110 with div_done -> res=0x16. Repeat with div_by_zero=1 -> err=1, err_code=10, res=0x00.
- Mode 100 with no mul_done -> err_code=01 and res_valid=1 after exactly TIMEOUT(16) cycles in WAIT. Repeat with mul_done=1 (mul_res=0x51) landing on the 16th cycle -> res=0x51, err=0.
- Mode 110 on start -> ERR with err_code=11. While in ERR, pulse sqr_done and alu_valid -> no change. res_ready -> IDLE, err=0.
- Mode 001: pulse mul_done and alu_valid while in WAIT -> ignored. Then sqr_done with sqr_res=4'hB -> res=0x0B. Keep res_ready low for 5 cycles -> res_valid and res stable throughout.
- rst=1 in WAIT (mode 100), then mul_done=1 one cycle after rst drops -> no capture, res_valid=0, state IDLE. A subsequent normal ALU operation completes correctly.
